// File: rtl/pwm_pkg.sv
// Shared PWM types and defaults for the duty sequencer and pwm_generator.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        STOP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pwm_ramp_prescaler.sv
// Ramp-rate prescaler: counts 0..RAMP_DIV-1 while enabled, ticks on the last count.
module pwm_ramp_prescaler
    import pwm_pkg::*;
#(
    parameter int RAMP_DIV = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(RAMP_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Slews duty_cycle toward an accepted target in steps of at most STEP per tick.
// Define PWM_SEQ_ESTOP_EN to add the estop port and the STOP state.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int STEP     = 4,
    parameter int RAMP_DIV = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tgt_duty,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             busy,
    output logic             done
`ifdef PWM_SEQ_ESTOP_EN
    ,
    input  logic             estop
`endif
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mag, step_amt, stepped;
    logic             accept, tick, going_up, ps_clear, ps_enable;

    assign tgt_ready  = (state_q != STOP);
    assign accept     = tgt_valid && tgt_ready;
    assign ps_enable  = (state_q == RAMP);
    assign ps_clear   = !ps_enable;

    // Larger-minus-smaller keeps the distance and the step free of wrap.
    assign going_up = (target_q > duty_q);
    assign mag      = going_up ? (target_q - duty_q) : (duty_q - target_q);
    assign step_amt = (mag < STEP_W) ? mag : STEP_W;
    assign stepped  = going_up ? (duty_q + step_amt) : (duty_q - step_amt);

    pwm_ramp_prescaler #(
        .RAMP_DIV(RAMP_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (ps_clear),
        .enable (ps_enable),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;
        if (accept) begin
            target_d = tgt_duty;
        end
        unique case (state_q)
            IDLE: begin
                if (accept && (tgt_duty != duty_q)) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                // Step toward the old target; finish against the new one.
                if (tick) begin
                    duty_d = stepped;
                end
                if (duty_d == target_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef PWM_SEQ_ESTOP_EN
        if (estop) begin
            state_d  = STOP;
            duty_d   = '0;
            target_d = '0;
            done_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    assign duty_cycle = duty_q;
    assign busy       = (state_q == RAMP);
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with STEP=4, RAMP_DIV=4.
module tb_pwm_duty_sequencer;

    typedef enum {OP_RST, OP_SEND, OP_WAIT} op_t;

    typedef struct {
        op_t        op;
        logic [7:0] tgt;
        int         k;
        int         duty;
        int         busy;
        int         done;
        int         dn;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] tgt_duty;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;
    logic       estop;

    int total = 0;
    int passed = 0;
    int dn = 0;
    int k = 0;
    int prev = 0;
    int maxj = 0;
    vec_t tbl[$];

    pwm_duty_sequencer #(
        .WIDTH(8),
        .STEP(4),
        .RAMP_DIV(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tgt_duty  (tgt_duty),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .duty_cycle(duty_cycle),
        .busy      (busy),
        .done      (done)
`ifdef PWM_SEQ_ESTOP_EN
        ,
        .estop     (estop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        int j;
        @(posedge clk);
        #1;
        if (done) dn++;
        j = (int'(duty_cycle) > prev) ? int'(duty_cycle) - prev
                                      : prev - int'(duty_cycle);
        if (j > maxj) maxj = j;
        prev = int'(duty_cycle);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        prev = 0;
        dn = 0;
        k = 0;
    endtask

    task automatic send(input logic [7:0] t);
        tgt_duty = t;
        tgt_valid = 1'b1;
        dn = 0;
        cyc();
        tgt_valid = 1'b0;
        k = 0;
    endtask

    task automatic add(input op_t op, input int t, input int kk, input int d,
                       input int b, input int dv, input int n);
        vec_t v;
        v.op = op;
        v.tgt = 8'(t);
        v.k = kk;
        v.duty = d;
        v.busy = b;
        v.done = dv;
        v.dn = n;
        tbl.push_back(v);
    endtask

    initial begin
        reset_n = 1'b0;
        tgt_valid = 1'b0;
        tgt_duty = 8'd0;
        estop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_duty", int'(duty_cycle), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(tgt_ready), 1);

        // ramp up 0->128
        add(OP_SEND, 128, 0,   0, 1, 0, 0);
        add(OP_WAIT, 0,   3,   0, 1, 0, 0);
        add(OP_WAIT, 0,   4,   4, 1, 0, 0);
        add(OP_WAIT, 0,   64,  64, 1, 0, 0);
        add(OP_WAIT, 0,   127, 124, 1, 0, 0);
        add(OP_WAIT, 0,   128, 128, 0, 1, 1);
        add(OP_WAIT, 0,   130, 128, 0, 0, 1);
        // ramp down 128->0
        add(OP_SEND, 0,   0,   128, 1, 0, 0);
        add(OP_WAIT, 0,   4,   124, 1, 0, 0);
        add(OP_WAIT, 0,   127, 4, 1, 0, 0);
        add(OP_WAIT, 0,   128, 0, 0, 1, 1);
        add(OP_WAIT, 0,   129, 0, 0, 0, 1);
        // full scale with partial last step
        add(OP_SEND, 255, 0,   0, 1, 0, 0);
        add(OP_WAIT, 0,   252, 252, 1, 0, 0);
        add(OP_WAIT, 0,   255, 252, 1, 0, 0);
        add(OP_WAIT, 0,   256, 255, 0, 1, 1);
        add(OP_WAIT, 0,   258, 255, 0, 0, 1);
        // retarget mid-ramp, no prescaler restart
        add(OP_RST,  0,   0,   0, 0, 0, 0);
        add(OP_SEND, 200, 0,   0, 1, 0, 0);
        add(OP_WAIT, 0,   100, 100, 1, 0, 0);
        add(OP_SEND, 40,  0,   100, 1, 0, 0);
        add(OP_WAIT, 0,   2,   100, 1, 0, 0);
        add(OP_WAIT, 0,   3,   96, 1, 0, 0);
        add(OP_WAIT, 0,   58,  44, 1, 0, 0);
        add(OP_WAIT, 0,   59,  40, 0, 1, 1);
        add(OP_WAIT, 0,   61,  40, 0, 0, 1);
        // accept on a tick edge steps toward the old target
        add(OP_SEND, 60,  0,   40, 1, 0, 0);
        add(OP_WAIT, 0,   7,   44, 1, 0, 0);
        add(OP_SEND, 0,   0,   48, 1, 0, 0);
        add(OP_WAIT, 0,   4,   44, 1, 0, 0);
        add(OP_WAIT, 0,   47,  4, 1, 0, 0);
        add(OP_WAIT, 0,   48,  0, 0, 1, 1);
        // repeat of current value while idle
        add(OP_SEND, 0,   0,   0, 0, 0, 0);
        add(OP_WAIT, 0,   3,   0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_RST: begin
                    do_reset();
                    chk($sformatf("v%0d_rst_duty", i), int'(duty_cycle), 0);
                end
                OP_SEND, OP_WAIT: begin
                    if (tbl[i].op == OP_SEND) begin
                        send(tbl[i].tgt);
                    end
                    while (k < tbl[i].k) begin
                        cyc();
                        k++;
                    end
                    chk($sformatf("v%0d_duty", i), int'(duty_cycle), tbl[i].duty);
                    chk($sformatf("v%0d_busy", i), int'(busy), tbl[i].busy);
                    chk($sformatf("v%0d_done", i), int'(done), tbl[i].done);
                    chk($sformatf("v%0d_ndone", i), dn, tbl[i].dn);
                end
                default: ;
            endcase
        end
        chk("max_jump_le_step", (maxj <= 4) ? 1 : 0, 1);

        // async reset mid-ramp, no clock edge needed
        do_reset();
        send(8'd100);
        repeat (20) cyc();
        chk("mid_duty", int'(duty_cycle), 20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_duty", int'(duty_cycle), 0);
        chk("async_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("post_rst_ready", int'(tgt_ready), 1);
        chk("post_rst_duty", int'(duty_cycle), 0);

`ifdef PWM_SEQ_ESTOP_EN
        send(8'd200);
        repeat (96) cyc();
        chk("es_pre_duty", int'(duty_cycle), 96);
        estop = 1'b1;
        tgt_duty = 8'd50;
        tgt_valid = 1'b1;
        cyc();
        chk("es_duty", int'(duty_cycle), 0);
        chk("es_ready", int'(tgt_ready), 0);
        chk("es_busy", int'(busy), 0);
        chk("es_done", int'(done), 0);
        cyc();
        chk("es_hold_duty", int'(duty_cycle), 0);
        chk("es_hold_ready", int'(tgt_ready), 0);
        estop = 1'b0;
        cyc();
        tgt_valid = 1'b0;
        chk("es_rel_ready", int'(tgt_ready), 1);
        chk("es_rel_busy", int'(busy), 0);
        chk("es_rel_duty", int'(duty_cycle), 0);
        send(8'd8);
        chk("es_resume_busy", int'(busy), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
